instr_fetch: RTL

Instruction-fetch stage of the MIPS CPU: owns the program counter, drives the byte-addressed big-endian instruction ROM (Address, nrd), and captures the returned word into an instruction register (IR) for decode. Computes next PC (sequential, branch, jump, jump-register), flushes the wrong-path instruction on redirect, and supports a downstream stall. Sits directly upstream of the instruction ROM and feeds the decoder.

---
 rtl/cpu_pkg.sv | 20 ++
 rtl/next_pc_calc.sv | 31 +++
 rtl/instr_fetch.sv | 116 +++++++++++
 3 files changed

// File: rtl/cpu_pkg.sv
// Shared definitions for the MIPS fetch stage: PC source selects, NOP word
// and fetch state encoding.
package cpu_pkg;

    typedef enum logic [1:0] {
        PC_SEQ = 2'b00,
        PC_BR  = 2'b01,
        PC_J   = 2'b10,
        PC_JR  = 2'b11
    } pc_src_e;

    typedef enum logic [1:0] {
        BOOT  = 2'b00,
        RUN   = 2'b01,
        FAULT = 2'b10
    } fetch_state_e;

    localparam logic [31:0] NOP = 32'h0000_0000;

endpackage

// File: rtl/next_pc_calc.sv
// Combinational redirect target for branch / jump / jump-register, plus
// misalignment detection on the register target.
module next_pc_calc
    import cpu_pkg::*;
(
    input  pc_src_e     pc_src_i,
    input  logic [31:0] ir_pc4_i,
    input  logic [15:0] branch_imm_i,
    input  logic [25:0] jump_target_i,
    input  logic [31:0] reg_target_i,
    output logic [31:0] target_o,
    output logic        align_err_o
);

    logic [31:0] br_offset;

    assign br_offset = {{14{branch_imm_i[15]}}, branch_imm_i, 2'b00};

    always_comb begin
        target_o = ir_pc4_i;
        unique case (pc_src_i)
            PC_BR:   target_o = ir_pc4_i + br_offset;
            PC_J:    target_o = {ir_pc4_i[31:28], jump_target_i, 2'b00};
            PC_JR:   target_o = {reg_target_i[31:2], 2'b00};
            default: target_o = ir_pc4_i;
        endcase
    end

    assign align_err_o = (pc_src_i == PC_JR) && (reg_target_i[1:0] != 2'b00);

endmodule

// File: rtl/instr_fetch.sv
// Fetch stage: owns the PC, reads the instruction ROM and latches IR/IR_PC4,
// with redirect flush, stall and out-of-range fault handling.
module instr_fetch
    import cpu_pkg::*;
#(
    parameter logic [31:0] RESET_PC  = 32'h0000_0000,
    parameter int unsigned ROM_BYTES = 100
) (
    input  logic        CLK,
    input  logic        Reset,
    input  logic        PCWre,
    input  logic [1:0]  PCSrc,
    input  logic [15:0] BranchImm,
    input  logic [25:0] JumpTarget,
    input  logic [31:0] RegTarget,
    input  logic [31:0] DataIn,
    output logic [31:0] Address,
    output logic        nrd,
    output logic [31:0] IR,
    output logic [31:0] IR_PC4,
    output logic        IR_Valid,
    output logic        FetchFault,
    output logic        AlignErr
);

    localparam logic [31:0] LAST_PC = 32'(ROM_BYTES - 4);

    fetch_state_e state_q;
    logic [31:0]  pc_q;
    logic [31:0]  ir_q;
    logic [31:0]  ir_pc4_q;
    logic         ir_valid_q;
    logic         fault_q;
    logic         align_q;

    pc_src_e      pc_src;
    logic [31:0]  target;
    logic         align_err;
    logic [31:0]  pc_seq_d;
    logic         redirect;
    logic         pc_in_range;
    logic         target_in_range;

    assign pc_src          = pc_src_e'(PCSrc);
    assign redirect        = (pc_src != PC_SEQ);
    assign pc_seq_d        = pc_q + 32'd4;
    assign pc_in_range     = (pc_q <= LAST_PC);
    assign target_in_range = (target <= LAST_PC);

    next_pc_calc u_next_pc_calc (
        .pc_src_i      (pc_src),
        .ir_pc4_i      (ir_pc4_q),
        .branch_imm_i  (BranchImm),
        .jump_target_i (JumpTarget),
        .reg_target_i  (RegTarget),
        .target_o      (target),
        .align_err_o   (align_err)
    );

    always_ff @(posedge CLK or negedge Reset) begin
        if (!Reset) begin
            state_q    <= BOOT;
            pc_q       <= RESET_PC;
            ir_q       <= NOP;
            ir_pc4_q   <= '0;
            ir_valid_q <= 1'b0;
            fault_q    <= 1'b0;
            align_q    <= 1'b0;
        end else begin
            align_q <= 1'b0;
            case (state_q)
                BOOT: state_q <= RUN;
                RUN: begin
                    // A redirect resolves from the instruction already in IR,
                    // so it outranks both the stall and the range check.
                    if (redirect) begin
                        pc_q       <= target;
                        ir_q       <= NOP;
                        ir_valid_q <= 1'b0;
                        align_q    <= align_err;
                    end else if (!pc_in_range) begin
                        state_q    <= FAULT;
                        fault_q    <= 1'b1;
                        ir_q       <= NOP;
                        ir_valid_q <= 1'b0;
                    end else if (PCWre) begin
                        ir_q       <= DataIn;
                        ir_pc4_q   <= pc_seq_d;
                        ir_valid_q <= 1'b1;
                        pc_q       <= pc_seq_d;
                    end
                end
                FAULT: begin
                    if (redirect) begin
                        align_q <= align_err;
                    end
                    if (redirect && target_in_range) begin
                        pc_q    <= target;
                        state_q <= RUN;
                        fault_q <= 1'b0;
                    end
                end
                default: state_q <= BOOT;
            endcase
        end
    end

    assign Address    = pc_q;
    assign nrd        = (state_q != RUN);
    assign IR         = ir_q;
    assign IR_PC4     = ir_pc4_q;
    assign IR_Valid   = ir_valid_q;
    assign FetchFault = fault_q;
    assign AlignErr   = align_q;

endmodule
